// File: rtl/am_envelope_detector_if.sv
// Sample-in / envelope-out stream bundle for am_envelope_detector.
// master drives samples and m_ready; slave (the detector) returns the envelope stream.
interface am_envelope_detector_if #(
  parameter int unsigned IN_W = 32
);
  logic                   s_valid;
  logic signed [IN_W-1:0] s_data;
  logic                   m_ready;
  logic                   m_valid;
  logic [IN_W-1:0]        m_data;

  modport master (
    output s_valid,
    output s_data,
    output m_ready,
    input  m_valid,
    input  m_data
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  m_ready,
    output m_valid,
    output m_data
  );
endinterface

// File: rtl/am_envelope_detector.sv
// Peak-hold envelope detector: |x| -> attack/hold/shift-release tracker -> decimated output.
// Optional level monitor (peak_out/peak_clr) is built when ENV_PEAK_MON_EN is defined.
module am_envelope_detector #(
  parameter int unsigned IN_W         = 32,
  parameter int unsigned DECAY_SHIFT  = 6,
  parameter int unsigned HOLD_SAMPLES = 8,
  parameter int unsigned DECIM        = 4
) (
  input  logic                   clk_pin,
  input  logic                   reset_pin,
  am_envelope_detector_if.slave  bus,
  output logic                   overrun
`ifdef ENV_PEAK_MON_EN
  ,
  input  logic                   peak_clr,
  output logic [IN_W-1:0]        peak_out
`endif
);

  localparam int unsigned HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_SAMPLES);
  localparam logic [IN_W-1:0]   ONE_V     = IN_W'(1);
  localparam logic [IN_W-1:0]   MAX_POS   = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [7:0]        DEC_LAST  = 8'(DECIM - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Stage A
  logic [IN_W-1:0] abs_c;
  logic [IN_W-1:0] abs_r;
  logic            abs_v;

  // Stage B
  logic [IN_W-1:0]   env_q, env_d;
  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              upd_q;
  logic [IN_W-1:0]   decay;
  logic [IN_W-1:0]   rel_step;

  // Stage C
  logic [7:0]      dec_cnt;
  logic            emit;
  logic            m_valid_q;
  logic [IN_W-1:0] m_data_q;
  logic            overrun_q;

  // Magnitude of the incoming sample; the most negative code saturates to the largest positive.
  always_comb begin
    abs_c = bus.s_data;
    if (bus.s_data[IN_W-1]) begin
      if (bus.s_data[IN_W-2:0] == '0) begin
        abs_c = MAX_POS;
      end else begin
        abs_c = (~bus.s_data) + ONE_V;
      end
    end
  end

  // Stage A register; abs_r holds during s_valid gaps so stage B sees no new work.
  always_ff @(posedge clk_pin or posedge reset_pin) begin
    if (reset_pin) begin
      abs_r <= '0;
      abs_v <= 1'b0;
    end else begin
      abs_v <= bus.s_valid;
      if (bus.s_valid) begin
        abs_r <= abs_c;
      end
    end
  end

  // Release step is env >> DECAY_SHIFT, but never smaller than 1 so small tails still drain.
  always_comb begin
    decay    = env_q >> DECAY_SHIFT;
    rel_step = (decay == '0) ? ONE_V : decay;
  end

  // Envelope tracker next state; attack wins over every other state action.
  always_comb begin
    env_d   = env_q;
    state_d = state_q;
    hold_d  = hold_q;
    if (abs_v) begin
      if ((abs_r != '0) && (abs_r >= env_q)) begin
        env_d   = abs_r;
        hold_d  = HOLD_INIT;
        state_d = (HOLD_SAMPLES == 0) ? ST_RELEASE : ST_HOLD;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (hold_q <= HOLD_W'(1)) begin
              hold_d  = '0;
              state_d = ST_RELEASE;
            end else begin
              hold_d = hold_q - HOLD_W'(1);
            end
          end
          ST_RELEASE: begin
            env_d = (env_q > rel_step) ? (env_q - rel_step) : '0;
            if (env_d == '0) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            env_d   = '0;
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Stage B registers; upd_q marks that env_q was refreshed by a sample this cycle.
  always_ff @(posedge clk_pin or posedge reset_pin) begin
    if (reset_pin) begin
      env_q   <= '0;
      state_q <= ST_IDLE;
      hold_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      env_q   <= env_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      upd_q   <= abs_v;
    end
  end

  assign emit = upd_q && (dec_cnt == DEC_LAST);

  // Decimator and output register; an emit into an unconsumed slot overwrites and flags overrun.
  always_ff @(posedge clk_pin or posedge reset_pin) begin
    if (reset_pin) begin
      dec_cnt   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (upd_q) begin
        dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
      end
      if (emit) begin
        m_data_q  <= env_q;
        m_valid_q <= 1'b1;
        if (m_valid_q && !bus.m_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign overrun     = overrun_q;

`ifdef ENV_PEAK_MON_EN
  logic [IN_W-1:0] peak_q;

  // Running maximum of the envelope; a clear coinciding with an update restarts from the new env.
  always_ff @(posedge clk_pin or posedge reset_pin) begin
    if (reset_pin) begin
      peak_q <= '0;
    end else if (abs_v) begin
      if (peak_clr || (env_d > peak_q)) begin
        peak_q <= env_d;
      end
    end else if (peak_clr) begin
      peak_q <= '0;
    end
  end

  assign peak_out = peak_q;
`endif

endmodule

// File: tb/tb_am_envelope_detector.sv
// Directed bench for am_envelope_detector: a DECIM=4 instance for the output stream and a
// DECIM=1 instance that exposes every envelope update on m_data.
module tb_am_envelope_detector;

  logic clk_pin   = 1'b0;
  logic reset_pin = 1'b1;
  logic overrun4;
  logic overrun1;
  int   n_checks  = 0;
  int   n_pass    = 0;

  always #5 clk_pin = ~clk_pin;

  am_envelope_detector_if #(.IN_W(32)) bus4 ();
  am_envelope_detector_if #(.IN_W(32)) bus1 ();

`ifdef ENV_PEAK_MON_EN
  logic        peak_clr = 1'b0;
  logic [31:0] peak4;
  logic [31:0] peak1;
`endif

  am_envelope_detector #(
    .IN_W(32), .DECAY_SHIFT(6), .HOLD_SAMPLES(8), .DECIM(4)
  ) dut4 (
    .clk_pin   (clk_pin),
    .reset_pin (reset_pin),
    .bus       (bus4),
    .overrun   (overrun4)
`ifdef ENV_PEAK_MON_EN
    ,
    .peak_clr  (peak_clr),
    .peak_out  (peak4)
`endif
  );

  am_envelope_detector #(
    .IN_W(32), .DECAY_SHIFT(6), .HOLD_SAMPLES(8), .DECIM(1)
  ) dut1 (
    .clk_pin   (clk_pin),
    .reset_pin (reset_pin),
    .bus       (bus1),
    .overrun   (overrun1)
`ifdef ENV_PEAK_MON_EN
    ,
    .peak_clr  (peak_clr),
    .peak_out  (peak1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic signed [31:0] d);
    bus4.s_valid = v;
    bus1.s_valid = v;
    bus4.s_data  = d;
    bus1.s_data  = d;
  endtask

  // One sample, then idle until it has reached m_data of the DECIM=1 instance.
  task automatic step(input logic signed [31:0] d);
    drive(1'b1, d);
    @(negedge clk_pin);
    drive(1'b0, 32'sd0);
    repeat (2) @(negedge clk_pin);
  endtask

  logic [31:0] rel_exp [4] = '{32'd985, 32'd970, 32'd955, 32'd941};

  initial begin
    drive(1'b0, 32'sd0);
    bus4.m_ready = 1'b1;
    bus1.m_ready = 1'b1;
    repeat (2) @(negedge clk_pin);
    check("rst_m_valid", 32'(bus4.m_valid), 32'd0);
    check("rst_m_data", bus4.m_data, 32'd0);
    check("rst_overrun", 32'(overrun4), 32'd0);
    reset_pin = 1'b0;
    @(negedge clk_pin);

    // DC 1000 for 8 clocks: latency t+3 and one emit per 4 updates.
    for (int c = 0; c < 12; c++) begin
      drive(c < 8, 32'sd1000);
      @(negedge clk_pin);
      if (c + 1 == 2) check("lat_t2_valid", 32'(bus1.m_valid), 32'd0);
      if (c + 1 == 3) check("lat_t3_valid", 32'(bus1.m_valid), 32'd1);
      if (c + 1 == 3) check("lat_t3_data", bus1.m_data, 32'd1000);
      if (c + 1 == 5) check("dc_no_emit", 32'(bus4.m_valid), 32'd0);
      if (c + 1 == 6) check("dc_emit1_valid", 32'(bus4.m_valid), 32'd1);
      if (c + 1 == 6) check("dc_emit1_data", bus4.m_data, 32'd1000);
      if (c + 1 == 7) check("dc_consumed", 32'(bus4.m_valid), 32'd0);
      if (c + 1 == 10) check("dc_emit2_valid", 32'(bus4.m_valid), 32'd1);
    end
    check("dc_idle_valid", 32'(bus4.m_valid), 32'd0);
    check("dc_overrun", 32'(overrun4), 32'd0);

    // Step to 0: 8 held samples, then shift release.
    for (int i = 0; i < 8; i++) begin
      step(32'sd0);
      check($sformatf("hold_%0d", i), bus1.m_data, 32'd1000);
    end
    for (int i = 0; i < 4; i++) begin
      step(32'sd0);
      check($sformatf("release_%0d", i), bus1.m_data, rel_exp[i]);
    end

    // Reset between edges with a sample in flight.
    drive(1'b1, 32'sd1234);
    @(posedge clk_pin);
    #2;
    reset_pin = 1'b1;
    #1;
    check("midrst_m_valid", 32'(bus1.m_valid), 32'd0);
    check("midrst_m_data1", bus1.m_data, 32'd0);
    check("midrst_m_data4", bus4.m_data, 32'd0);
    check("midrst_overrun", 32'(overrun4), 32'd0);
`ifdef ENV_PEAK_MON_EN
    check("midrst_peak", peak4, 32'd0);
`endif
    reset_pin = 1'b0;
    drive(1'b0, 32'sd0);
    repeat (3) @(negedge clk_pin);
    check("midrst_dropped", 32'(bus1.m_valid), 32'd0);

    // Small tail: 40 decays by 1 per sample to 0 and never underflows.
    step(32'sd40);
    check("tail_attack", bus1.m_data, 32'd40);
    repeat (8) step(32'sd0);
    check("tail_hold_end", bus1.m_data, 32'd40);
    step(32'sd0);
    check("tail_first", bus1.m_data, 32'd39);
    repeat (38) step(32'sd0);
    check("tail_one", bus1.m_data, 32'd1);
    step(32'sd0);
    check("tail_zero", bus1.m_data, 32'd0);
    step(32'sd0);
    check("tail_floor", bus1.m_data, 32'd0);

    // Saturation of the most negative code; a small sample does not lower env during hold.
    step(32'sh8000_0000);
    check("sat_env", bus1.m_data, 32'h7FFF_FFFF);
    step(32'sd5);
    check("sat_hold", bus1.m_data, 32'h7FFF_FFFF);
`ifdef ENV_PEAK_MON_EN
    check("peak_max", peak4, 32'h7FFF_FFFF);
    peak_clr = 1'b1;
    @(negedge clk_pin);
    peak_clr = 1'b0;
    check("peak_clr", peak4, 32'd0);
`endif

    // Backpressure over two decimation periods.
    reset_pin = 1'b1;
    @(negedge clk_pin);
    reset_pin = 1'b0;
    bus4.m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) step(32'(i * 100));
    check("bp_emit1_valid", 32'(bus4.m_valid), 32'd1);
    check("bp_emit1_data", bus4.m_data, 32'd400);
    check("bp_emit1_ovr", 32'(overrun4), 32'd0);
    for (int i = 5; i <= 8; i++) step(32'(i * 100));
    check("bp_emit2_valid", 32'(bus4.m_valid), 32'd1);
    check("bp_emit2_data", bus4.m_data, 32'd800);
    check("bp_overrun", 32'(overrun4), 32'd1);
    bus4.m_ready = 1'b1;
    @(negedge clk_pin);
    check("bp_drained", 32'(bus4.m_valid), 32'd0);
    check("bp_sticky", 32'(overrun4), 32'd1);
    check("dec1_no_overrun", 32'(overrun1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
